// File: rtl/pipe_stage_chain.sv
// Purpose : parametrised pipeline register chain with per-stage valid, flush,
//           bubble collapse and an input skid buffer.
// Latency : STAGES cycles from in_fire to out_valid on an empty chain; 1 beat/cycle.
// Backpressure: out_ready stalls only occupied stages; a full stage 0 parks one beat
//           in the skid, and in_ready is registered so the input never sees out_ready.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream handshake (in_ready registered)
//   out_valid/out_ready/out_data  downstream handshake from stage STAGES-1
//   flush[STAGES]   flush[i] kills the beat in stage i; bit 0 also kills skid and input
//   occupancy       live beats in the stages plus the skid
//   stall_cnt       saturating count of cycles with out_valid & ~out_ready
//   stall_clr       synchronous clear of stall_cnt (wins over increment)
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    input  logic [STAGES-1:0]           flush,
    output logic [$clog2(STAGES+2)-1:0] occupancy,
    output logic [CNT_W-1:0]            stall_cnt,
    input  logic                        stall_clr
);

    localparam int OCC_W = $clog2(STAGES + 2);

    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0][WIDTH-1:0] d_q, d_d;
    logic                         skid_v_q, skid_v_d;
    logic [WIDTH-1:0]             skid_d_q, skid_d_d;
    logic                         in_ready_q, in_ready_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

    logic [STAGES-1:0]            adv;
    logic                         in_fire;
    logic [OCC_W-1:0]             occ;

    assign in_fire   = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = v_q[STAGES-1] & ~flush[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ;
    assign stall_cnt = stall_cnt_q;

    // A stage may take a new beat when its own beat leaves, is empty, or is
    // being killed. Propagating from the output end lets bubbles collapse.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready | ~v_q[STAGES-1] | flush[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~v_q[i] | flush[i];
        end
    end

    // Stage registers. Data is only loaded from a live source so an undriven
    // in_data never leaks X into the chain.
    always_comb begin
        v_d = v_q;
        d_d = d_q;

        if (adv[0]) begin
            v_d[0] = (skid_v_q | in_fire) & ~flush[0];
            if (skid_v_q) begin
                d_d[0] = skid_d_q;
            end else if (in_fire) begin
                d_d[0] = in_data;
            end
        end else if (flush[0]) begin
            v_d[0] = 1'b0;
        end

        for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                // A beat killed while moving leaves a bubble behind it.
                v_d[i] = v_q[i-1] & ~flush[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end else if (flush[i]) begin
                v_d[i] = 1'b0;
            end
        end
    end

    // Skid: catches the beat accepted in the cycle stage 0 could not move.
    // While the skid is full in_ready is low, so load and drain never overlap.
    always_comb begin
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;

        if (flush[0]) begin
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (adv[0]) begin
                skid_v_d = 1'b0;
            end
        end else if (in_fire & ~adv[0]) begin
            skid_v_d = 1'b1;
        end

        if (~skid_v_q & in_fire & ~adv[0]) begin
            skid_d_d = in_data;
        end

        in_ready_d = ~skid_v_d;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid & ~out_ready & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        occ = OCC_W'(skid_v_q);
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(v_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q         <= '0;
            d_q         <= '0;
            skid_v_q    <= 1'b0;
            skid_d_q    <= '0;
            in_ready_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            d_q         <= d_d;
            skid_v_q    <= skid_v_d;
            skid_d_q    <= skid_d_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Purpose : directed bench for pipe_stage_chain (STAGES=4, WIDTH=32, CNT_W=4).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: out_ready is driven directly by the directed steps.
module tb_pipe_stage_chain;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  flush;
    logic [2:0]  occupancy;
    logic [3:0]  stall_cnt;
    logic        stall_clr;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_chain #(.WIDTH(32), .STAGES(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;
        stall_clr = 1'b0;

        // ---------------- reset state and first-beat latency
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        chk("rel_in_ready_high", 64'(in_ready), 64'd1);

        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_occ1", 64'(occupancy), 64'd1);
        chk("lat_ov_e1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_ov_e2", 64'(out_valid), 64'd0);
        tick();
        chk("lat_ov_e3", 64'(out_valid), 64'd0);
        tick();
        chk("lat_ov_e4", 64'(out_valid), 64'd1);
        chk("lat_data",  64'(out_data),  64'hA5A5_0001);
        chk("lat_occ_e4", 64'(occupancy), 64'd1);
        tick();
        chk("lat_occ0", 64'(occupancy), 64'd0);
        chk("lat_ov_gone", 64'(out_valid), 64'd0);

        // ---------------- streaming 0..15 at full rate
        in_valid  = 1'b1;
        in_data   = 32'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("str_in_ready", 64'(in_ready), 64'd1);
            if (k >= 3) begin
                chk("str_ov",   64'(out_valid), 64'd1);
                chk("str_data", 64'(out_data),  64'(k - 3));
            end else begin
                chk("str_fill_ov", 64'(out_valid), 64'd0);
            end
            if (k == 15) begin
                in_valid = 1'b0;
            end else begin
                in_data = 32'(k + 1);
            end
        end
        for (int j = 16; j < 19; j++) begin
            tick();
            chk("str_tail_ov",   64'(out_valid), 64'd1);
            chk("str_tail_data", 64'(out_data),  64'(j - 3));
        end
        tick();
        chk("str_empty_ov",  64'(out_valid), 64'd0);
        chk("str_empty_occ", 64'(occupancy), 64'd0);
        chk("str_stall_cnt", 64'(stall_cnt), 64'd0);

        // ---------------- backpressure fills stages and skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'(100 + i);
            tick();
            if (i == 3) begin
                chk("bp_ov_e4",    64'(out_valid), 64'd1);
                chk("bp_stall_e4", 64'(stall_cnt), 64'd0);
            end
        end
        chk("bp_occ5",      64'(occupancy), 64'd5);
        chk("bp_in_ready0", 64'(in_ready),  64'd0);
        in_data = 32'd105;
        tick();
        tick();
        chk("bp_occ_hold",   64'(occupancy), 64'd5);
        chk("bp_in_ready_h", 64'(in_ready),  64'd0);
        chk("bp_stall3",     64'(stall_cnt), 64'd3);
        chk("bp_head",       64'(out_data),  64'd100);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready1", 64'(in_ready), 64'd1);
        for (int i = 1; i < 5; i++) begin
            if (i > 1) tick();
            chk("bp_drain_ov",   64'(out_valid), 64'd1);
            chk("bp_drain_data", 64'(out_data),  64'(100 + i));
        end
        tick();
        chk("bp_empty_ov",  64'(out_valid), 64'd0);
        chk("bp_empty_occ", 64'(occupancy), 64'd0);
        chk("bp_stall_fin", 64'(stall_cnt), 64'd3);

        // ---------------- bubble collapse: beats in stages 3 and 1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h31;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 32'h33;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bub_ov",   64'(out_valid), 64'd1);
        chk("bub_data", 64'(out_data),  64'h31);
        chk("bub_occ",  64'(occupancy), 64'd2);
        tick();
        chk("bub_hold_data", 64'(out_data),  64'h31);
        chk("bub_hold_occ",  64'(occupancy), 64'd2);
        out_ready = 1'b1;
        tick();
        chk("bub_next_ov",   64'(out_valid), 64'd1);
        chk("bub_next_data", 64'(out_data),  64'h33);
        tick();
        chk("bub_empty_occ", 64'(occupancy), 64'd0);
        chk("bub_empty_ov",  64'(out_valid), 64'd0);

        // ---------------- flush stages 0/1 with skid occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'(10 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("fl_occ5", 64'(occupancy), 64'd5);
        chk("fl_head", 64'(out_data),  64'd10);
        flush     = 4'b0011;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd15;
        #1;
        chk("fl_in_ready_blk", 64'(in_ready), 64'd0);
        tick();
        chk("fl_ov",       64'(out_valid), 64'd1);
        chk("fl_data",     64'(out_data),  64'd11);
        chk("fl_occ1",     64'(occupancy), 64'd1);
        chk("fl_in_ready", 64'(in_ready),  64'd1);
        // Same-cycle input beat under flush[0] is consumed and discarded.
        flush   = 4'b0001;
        in_data = 32'h16;
        tick();
        flush    = 4'b0000;
        in_valid = 1'b0;
        chk("fl_in_kill_occ", 64'(occupancy), 64'd0);
        chk("fl_in_kill_ov",  64'(out_valid), 64'd0);
        chk("fl_in_ready2",   64'(in_ready),  64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_nothing_ov", 64'(out_valid), 64'd0);
        end

        // ---------------- async reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'(32'h20 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("ar_occ5", 64'(occupancy), 64'd5);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_ov",       64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready),  64'd0);
        chk("ar_occ",      64'(occupancy), 64'd0);
        chk("ar_data",     64'(out_data),  64'd0);
        chk("ar_stall",    64'(stall_cnt), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("ar_in_ready_up", 64'(in_ready), 64'd1);

        // ---------------- stall counter saturation and clear
        in_valid = 1'b1;
        in_data  = 32'h77;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 3) chk("sat_start", 64'(stall_cnt), 64'd0);
            if (i == 17) chk("sat_14",   64'(stall_cnt), 64'd14);
        end
        chk("sat_15",    64'(stall_cnt), 64'd15);
        chk("sat_ov",    64'(out_valid), 64'd1);
        chk("sat_data",  64'(out_data),  64'h77);
        stall_clr = 1'b1;
        tick();
        chk("sat_clr", 64'(stall_cnt), 64'd0);
        stall_clr = 1'b0;
        tick();
        chk("sat_restart", 64'(stall_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
